skip_decoder: RTL and testbench

Receive-side companion to the clock-skip ring generator. Observes, per fast-clock cycle, whether the gated output clock produced a pulse (`V`) and where the ring is in its revolution (`B0`, `EN`). Reconstructs the skip mask the generator is applying and reports pulses per revolution. Flags any deviation from that pattern, so downstream logic can trust or reject the fractional clock.

---
 rtl/skip_pkg.sv | 16 +
 rtl/skip_slotctr.sv | 33 +++
 rtl/skip_decoder.sv | 127 ++++++++++++
 tb/tb_skip_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/skip_pkg.sv
// Shared types and width helpers for the clock-skip generator/decoder pair.
package skip_pkg;

   typedef enum logic [1:0] {IDLE, LEARN, VERIFY, LOCKED} skip_state_t;

   // Slot index width; a 2-slot ring still needs one bit.
   function automatic int slotw(input int len);
      return (len > 2) ? $clog2(len) : 1;
   endfunction

   // Width able to hold a count from 0 to len inclusive.
   function automatic int cntw(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/skip_slotctr.sv
// Ring slot tracker: current-slot selection, slot counter and phase check.
module skip_slotctr
   import skip_pkg::*;
#(
   parameter int LEN = 16,
   localparam int SLOTW = slotw(LEN)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             B0,
   input  logic             CHK,
   input  logic             ADV,
   input  logic             CLR,
   output logic [SLOTW-1:0] SLOT,
   output logic             PERR,
   output logic             LAST
);

   logic [SLOTW-1:0] cnt;

   assign SLOT = B0 ? '0 : cnt;
   assign LAST = (SLOT == SLOTW'(LEN - 1));
   assign PERR = EN && CHK && (B0 ? (cnt != '0) : (cnt == '0));

   always_ff @(posedge CLK) begin
      if (RST || CLR)
         cnt <= '0;
      else if (ADV)
         cnt <= LAST ? '0 : SLOT + SLOTW'(1);
   end

endmodule

// File: rtl/skip_decoder.sv
// Learns the generator's skip mask from observed pulses, then verifies it every revolution.
module skip_decoder
   import skip_pkg::*;
#(
   parameter int LEN  = 16,
   parameter int ERRW = 8,
   localparam int SLOTW = slotw(LEN),
   localparam int CNTW  = cntw(LEN)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            EN,
   input  logic            B0,
   input  logic            V,
   output logic [LEN-1:0]  MASK_Q,
   output logic [CNTW-1:0] NPASS,
   output logic            LOCK,
   output logic            ERR,
   output logic [ERRW-1:0] ERRCNT
);

   skip_state_t      state, state_d;
   logic [LEN-1:0]   shadow, shadow_d, mask_d;
   logic [CNTW-1:0]  pacc, pacc_d, npass_d, vext;
   logic             lock_d, err_d, adv, clr, s;
   logic [SLOTW-1:0] slot;
   logic             perr, last;

   skip_slotctr #(.LEN(LEN)) u_slotctr (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (EN),
      .B0   (B0),
      .CHK  (state != IDLE),
      .ADV  (adv),
      .CLR  (clr),
      .SLOT (slot),
      .PERR (perr),
      .LAST (last)
   );

   assign s    = ~V;
   assign vext = CNTW'(V);

   always_comb begin
      state_d  = state;
      shadow_d = shadow;
      pacc_d   = pacc;
      mask_d   = MASK_Q;
      npass_d  = NPASS;
      lock_d   = LOCK;
      err_d    = 1'b0;
      adv      = 1'b0;
      clr      = 1'b0;
      if (!EN) begin
         // Spurious skip while the ring is paused: flag it, keep the lock.
         err_d = ~V;
      end else begin
         unique case (state)
            IDLE: begin
               if (B0) begin
                  shadow_d[0] = s;
                  pacc_d      = vext;
                  adv         = 1'b1;
                  state_d     = LEARN;
               end
            end
            LEARN: begin
               if (perr) begin
                  err_d   = 1'b1;
                  lock_d  = 1'b0;
                  clr     = 1'b1;
                  state_d = IDLE;
               end else begin
                  shadow_d[slot] = s;
                  pacc_d         = pacc + vext;
                  adv            = 1'b1;
                  if (last) begin
                     mask_d  = shadow_d;
                     npass_d = pacc_d;
                     state_d = VERIFY;
                  end
               end
            end
            VERIFY, LOCKED: begin
               if (perr || (s != MASK_Q[slot])) begin
                  err_d   = 1'b1;
                  lock_d  = 1'b0;
                  clr     = 1'b1;
                  state_d = IDLE;
               end else begin
                  adv = 1'b1;
                  if (last && (state == VERIFY)) begin
                     lock_d  = 1'b1;
                     state_d = LOCKED;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         shadow <= '0;
         pacc   <= '0;
         MASK_Q <= '0;
         NPASS  <= '0;
         LOCK   <= 1'b0;
         ERR    <= 1'b0;
         ERRCNT <= '0;
      end else begin
         state  <= state_d;
         shadow <= shadow_d;
         pacc   <= pacc_d;
         MASK_Q <= mask_d;
         NPASS  <= npass_d;
         LOCK   <= lock_d;
         ERR    <= err_d;
         if (err_d && (ERRCNT != '1))
            ERRCNT <= ERRCNT + ERRW'(1);
      end
   end

endmodule

// File: tb/tb_skip_decoder.sv
// Directed bench for skip_decoder driven by a behavioural skip-ring generator.
module tb_skip_decoder;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        EN  = 1'b0;
   logic        B0  = 1'b0;
   logic        V   = 1'b1;
   logic [15:0] mask_q,  mask_q2;
   logic [4:0]  npass,   npass2;
   logic        lock,    lock2;
   logic        err,     err2;
   logic [7:0]  errcnt;
   logic [1:0]  errcnt2;

   int          total  = 0;
   int          passed = 0;
   int          gslot  = 0;
   int          nerr   = 0;
   int          n;
   logic [15:0] gmask  = 16'h0005;

   skip_decoder #(.LEN(16), .ERRW(8)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .B0(B0), .V(V),
      .MASK_Q(mask_q), .NPASS(npass), .LOCK(lock), .ERR(err), .ERRCNT(errcnt)
   );

   skip_decoder #(.LEN(16), .ERRW(2)) dut_sat (
      .CLK(CLK), .RST(RST), .EN(EN), .B0(B0), .V(V),
      .MASK_Q(mask_q2), .NPASS(npass2), .LOCK(lock2), .ERR(err2), .ERRCNT(errcnt2)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         passed++;
   endtask

   // One generator cycle; outputs are inspected 1 ns after the sampling edge.
   task automatic step(input logic en_i, input logic b0_force, input logic v0_force);
      EN = en_i;
      B0 = (gslot == 0) || b0_force;
      V  = en_i ? ~gmask[gslot] : 1'b1;
      if (v0_force) V = 1'b0;
      @(posedge CLK);
      #1;
      if (en_i) gslot = (gslot + 1) % 16;
      if (err) nerr++;
   endtask

   initial begin
      // Reset
      RST = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("rst_mask",   32'(mask_q), 32'h0);
      chk("rst_npass",  32'(npass),  32'd0);
      chk("rst_lock",   32'(lock),   32'd0);
      chk("rst_err",    32'(err),    32'd0);
      chk("rst_errcnt", 32'(errcnt), 32'd0);
      RST = 1'b0;

      // Clean lock on 0x0005, entering mid-revolution
      gslot = 10;
      nerr  = 0;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 32; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (k == 14) chk("learn_mask_early", 32'(mask_q), 32'h0);
         if (k == 15) begin
            chk("learn_mask",  32'(mask_q), 32'h0005);
            chk("learn_npass", 32'(npass),  32'd14);
         end
         if (k == 30) chk("lock_early", 32'(lock), 32'd0);
         if (k == 31) chk("lock_at_32", 32'(lock), 32'd1);
      end
      chk("clean_no_err", 32'(nerr), 32'd0);

      // Mask change to 0x8001 at slot 2
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      gmask = 16'h8001;
      step(1'b1, 1'b0, 1'b0);
      chk("chg_err",    32'(err),    32'd1);
      chk("chg_lock",   32'(lock),   32'd0);
      chk("chg_errcnt", 32'(errcnt), 32'd1);
      n = 0;
      do begin
         step(1'b1, 1'b0, 1'b0);
         n++;
         if (n == 1) chk("chg_err_single", 32'(err), 32'd0);
      end while (!lock && n < 100);
      chk("chg_relock_cycles", 32'(n), 32'd45);
      chk("chg_mask",  32'(mask_q), 32'h8001);
      chk("chg_npass", 32'(npass),  32'd14);

      // Phase slip: B0 forced at counter 7
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("slip_err",    32'(err),    32'd1);
      chk("slip_lock",   32'(lock),   32'd0);
      chk("slip_errcnt", 32'(errcnt), 32'd2);
      n = 0;
      do begin
         step(1'b1, 1'b0, 1'b0);
         n++;
      end while (!lock && n < 100);
      chk("slip_relock_cycles", 32'(n), 32'd40);

      // Enable gaps with V=1: lock holds, ring pauses
      nerr = 0;
      n    = 0;
      for (int i = 0; i < 64; i++) begin
         step(($urandom_range(0, 2) != 0), 1'b0, 1'b0);
         if (!lock) n++;
      end
      chk("gap_lock_held", 32'(n),    32'd0);
      chk("gap_no_err",    32'(nerr), 32'd0);
      step(1'b0, 1'b0, 1'b1);
      chk("gap_spur_err",    32'(err),    32'd1);
      chk("gap_spur_lock",   32'(lock),   32'd1);
      chk("gap_spur_errcnt", 32'(errcnt), 32'd3);
      step(1'b1, 1'b0, 1'b0);
      chk("gap_err_clear", 32'(err),  32'd0);
      chk("gap_lock_after", 32'(lock), 32'd1);

      // Saturation: ERRW=2 counter stops at 3
      RST = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      RST = 1'b0;
      chk("sat_rst_errcnt", 32'(errcnt2), 32'd0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
      chk("sat_errcnt2", 32'(errcnt2), 32'd3);
      chk("sat_errcnt8", 32'(errcnt),  32'd5);

      // Learn 0x0005, slip into IDLE, relearn partway, then reset mid-LEARN
      gmask = 16'h0005;
      gslot = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
      chk("pre_rst_mask", 32'(mask_q), 32'h0005);
      step(1'b1, 1'b1, 1'b0);
      chk("pre_rst_err", 32'(err), 32'd1);
      n = 0;
      while (gslot != 0 && n < 32) begin
         step(1'b1, 1'b0, 1'b0);
         n++;
      end
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      RST = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      RST = 1'b0;
      chk("mid_rst_mask",   32'(mask_q),  32'h0);
      chk("mid_rst_npass",  32'(npass),   32'd0);
      chk("mid_rst_lock",   32'(lock),    32'd0);
      chk("mid_rst_err",    32'(err),     32'd0);
      chk("mid_rst_errcnt", 32'(errcnt),  32'd0);
      chk("mid_rst_sat",    32'(errcnt2), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
